// File: rtl/alu_mdu_seq_pkg.sv
// alu_mdu_seq_pkg
// Shared definitions for the alu_mdu_seq execute unit:
//   - 5-bit operation codes (base integer ops plus multiply/divide)
//   - bit positions of the compare-flag vector {geu,ltu,ge,lt,ne,eq}
//   - FSM state encodings and single-bit ENABLE/DISABLE values
//   - small op-classification helpers used by the datapath
package alu_mdu_seq_pkg;

  typedef enum logic [4:0] {
    ALU_OP_ADD    = 5'd0,
    ALU_OP_SUB    = 5'd1,
    ALU_OP_SLL    = 5'd2,
    ALU_OP_SLT    = 5'd3,
    ALU_OP_SLTU   = 5'd4,
    ALU_OP_XOR    = 5'd5,
    ALU_OP_SRL    = 5'd6,
    ALU_OP_SRA    = 5'd7,
    ALU_OP_OR     = 5'd8,
    ALU_OP_AND    = 5'd9,
    ALU_OP_MUL    = 5'd10,
    ALU_OP_MULH   = 5'd11,
    ALU_OP_MULHSU = 5'd12,
    ALU_OP_MULHU  = 5'd13,
    ALU_OP_DIV    = 5'd14,
    ALU_OP_DIVU   = 5'd15,
    ALU_OP_REM    = 5'd16,
    ALU_OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam int CMP_EQ  = 0;
  localparam int CMP_NE  = 1;
  localparam int CMP_LT  = 2;
  localparam int CMP_GE  = 3;
  localparam int CMP_LTU = 4;
  localparam int CMP_GEU = 5;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  function automatic logic op_is_mul(input logic [4:0] o);
    case (o)
      ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU: return ENABLE;
      default: return DISABLE;
    endcase
  endfunction

  function automatic logic op_is_div(input logic [4:0] o);
    case (o)
      ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU: return ENABLE;
      default: return DISABLE;
    endcase
  endfunction

  // src1 is treated as two's complement by these ops
  function automatic logic op_src1_signed(input logic [4:0] o);
    case (o)
      ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_DIV, ALU_OP_REM: return ENABLE;
      default: return DISABLE;
    endcase
  endfunction

  // src2 is treated as two's complement by these ops
  function automatic logic op_src2_signed(input logic [4:0] o);
    case (o)
      ALU_OP_MULH, ALU_OP_DIV, ALU_OP_REM: return ENABLE;
      default: return DISABLE;
    endcase
  endfunction

endpackage

// File: rtl/alu_mdu_seq_div.sv
// alu_div_iter
// Unsigned restoring divider, one quotient bit per cycle. Operands are
// magnitudes; sign handling lives in the parent. The load cycle also performs
// the first step, so o_done is high XLEN cycles after i_start.
// Ports:
//   clk, rst_n (sync active-low), i_abort (drop current divide),
//   i_start + i_dividend/i_divisor (load), o_busy, o_done (one-cycle pulse),
//   o_quotient / o_remainder (valid while o_done).
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_abort,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quot;
  logic [XLEN-1:0]  r_dsor;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  // Shift the next dividend bit into the partial remainder and keep the
  // subtraction only when it does not go negative; returns {rem, quot}.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quot,
                                                 input logic [XLEN-1:0] dsor);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    shifted = {rem, quot[XLEN-1]};
    trial   = shifted - {1'b0, dsor};
    if (trial[XLEN]) begin
      return {shifted[XLEN-1:0], quot[XLEN-2:0], 1'b0};
    end else begin
      return {trial[XLEN-1:0], quot[XLEN-2:0], 1'b1};
    end
  endfunction

  // Divider state: load+first step on start, one step per busy cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem  <= {XLEN{1'b0}};
      r_quot <= {XLEN{1'b0}};
      r_dsor <= {XLEN{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      r_busy <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_busy <= 1'b0;
    end else if (i_start) begin
      {r_rem, r_quot} <= div_step({XLEN{1'b0}}, i_dividend, i_divisor);
      r_dsor <= i_divisor;
      r_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt  <= {CNT_W{1'b0}};
        r_busy <= 1'b0;
      end else begin
        {r_rem, r_quot} <= div_step(r_rem, r_quot, r_dsor);
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_busy && (r_cnt == CNT_LAST);
  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;

endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq
// Valid/ready EX-stage execute unit: base integer ops in one registered cycle,
// multiply/divide iterative over XLEN cycles (accept-to-out_valid = XLEN+1).
// Build option: define MDU_FAST_MUL_EN to replace the iterative multiplier by
// a single-cycle combinational one (latency 1); divide stays iterative.
// Ports:
//   clk, rst_n (sync active-low), flush (abort, beats everything but reset)
//   in_valid/in_ready, op[4:0], src1, src2 : operation request
//   out_valid/out_ready, result, cmp[5:0] : registered response,
//   cmp = {geu,ltu,ge,lt,ne,eq} from the accepted operands
module alu_mdu_seq
  import alu_mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [5:0]      cmp
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int CNT_W   = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

  mdu_state_e          r_state;
  logic                r_out_valid;
  logic [XLEN-1:0]     r_result;
  logic [5:0]          r_cmp;
  logic [CNT_W-1:0]    r_cnt;
  logic [4:0]          r_op;
  logic [XLEN-1:0]     r_src1;
  logic                r_neg;
  logic                r_rneg;
  logic                r_dz;
  logic [2*XLEN-1:0]   r_prod;
  logic [XLEN-1:0]     r_mcand;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_s1_neg;
  logic                w_s2_neg;
  logic [XLEN-1:0]     w_mag1;
  logic [XLEN-1:0]     w_mag2;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [XLEN-1:0]     w_fast_result;
  logic [2*XLEN-1:0]   w_prod_final;
  logic                w_div_busy;
  logic                w_div_done;
  logic [XLEN-1:0]     w_div_q;
  logic [XLEN-1:0]     w_div_r;
  logic [XLEN-1:0]     w_quot;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_div_result;

  function automatic logic [5:0] cmp_flags(input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    logic [5:0] f;
    f          = 6'b0;
    f[CMP_EQ]  = (a == b);
    f[CMP_NE]  = (a != b);
    f[CMP_LT]  = ($signed(a) < $signed(b));
    f[CMP_GE]  = !($signed(a) < $signed(b));
    f[CMP_LTU] = (a < b);
    f[CMP_GEU] = !(a < b);
    return f;
  endfunction

  // One shift-add step on {hi, lo}: lo starts as the multiplier, hi gathers
  // partial sums; after XLEN steps the pair is the full product.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                 input logic [XLEN-1:0]   mcand);
    logic [XLEN:0] sum;
    sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    return {sum, p[XLEN-1:1]};
  endfunction

  function automatic logic [XLEN-1:0] mul_pick(input logic [4:0]        o,
                                               input logic [2*XLEN-1:0] p);
    if (o == ALU_OP_MUL) begin
      return p[XLEN-1:0];
    end else begin
      return p[2*XLEN-1:XLEN];
    end
  endfunction

  // in_ready also drops while the divider is still winding down; it never is
  // in IDLE, but accepting then would corrupt its state.
  assign w_in_ready = rst_n && !flush && (r_state == ST_IDLE) && !w_div_busy;
  assign w_accept   = in_valid && w_in_ready;

  // Signed ops work on magnitudes; signs are re-applied on the way out
  assign w_s1_neg = op_src1_signed(op) && src1[XLEN-1];
  assign w_s2_neg = op_src2_signed(op) && src2[XLEN-1];
  assign w_mag1   = w_s1_neg ? -src1 : src1;
  assign w_mag2   = w_s2_neg ? -src2 : src2;
  assign w_shamt  = src2[SHAMT_W-1:0];

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_mag;
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_mag  = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
  assign w_fast_prod = (w_s1_neg ^ w_s2_neg) ? -w_fast_mag : w_fast_mag;
`endif

  // Result for every op that completes in the accept cycle
  always_comb begin
    w_fast_result = {XLEN{1'b0}};
    case (op)
      ALU_OP_ADD:  w_fast_result = src1 + src2;
      ALU_OP_SUB:  w_fast_result = src1 - src2;
      ALU_OP_SLL:  w_fast_result = src1 << w_shamt;
      ALU_OP_SLT:  w_fast_result = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALU_OP_SLTU: w_fast_result = {{(XLEN-1){1'b0}}, (src1 < src2)};
      ALU_OP_XOR:  w_fast_result = src1 ^ src2;
      ALU_OP_SRL:  w_fast_result = src1 >> w_shamt;
      ALU_OP_SRA:  w_fast_result = $unsigned($signed(src1) >>> w_shamt);
      ALU_OP_OR:   w_fast_result = src1 | src2;
      ALU_OP_AND:  w_fast_result = src1 & src2;
`ifdef MDU_FAST_MUL_EN
      ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU:
                   w_fast_result = mul_pick(op, w_fast_prod);
`endif
      default:     w_fast_result = {XLEN{1'b0}};
    endcase
  end

  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_abort     (flush),
    .i_start     (w_accept && op_is_div(op)),
    .i_dividend  (w_mag1),
    .i_divisor   (w_mag2),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r)
  );

  // Divide-by-zero bypasses sign fix-up: quotient all ones, remainder = src1.
  // Signed overflow falls out naturally (|MIN|/1 re-negated is MIN, rem 0).
  assign w_quot       = r_dz ? {XLEN{1'b1}} : (r_neg  ? -w_div_q : w_div_q);
  assign w_rem        = r_dz ? r_src1       : (r_rneg ? -w_div_r : w_div_r);
  assign w_div_result = ((r_op == ALU_OP_DIV) || (r_op == ALU_OP_DIVU)) ? w_quot : w_rem;
  assign w_prod_final = r_neg ? -r_prod : r_prod;

  // Control FSM plus all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= {XLEN{1'b0}};
      r_cmp       <= 6'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_op        <= 5'd0;
      r_src1      <= {XLEN{1'b0}};
      r_neg       <= 1'b0;
      r_rneg      <= 1'b0;
      r_dz        <= 1'b0;
      r_prod      <= {(2*XLEN){1'b0}};
      r_mcand     <= {XLEN{1'b0}};
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cmp  <= cmp_flags(src1, src2);
            r_op   <= op;
            r_src1 <= src1;
            r_neg  <= w_s1_neg ^ w_s2_neg;
            r_rneg <= w_s1_neg;
            r_dz   <= (src2 == {XLEN{1'b0}});
            if (op_is_div(op)) begin
              r_state <= ST_BUSY;
`ifndef MDU_FAST_MUL_EN
            end else if (op_is_mul(op)) begin
              // First shift-add step happens on the accept edge
              r_prod  <= mul_step({{XLEN{1'b0}}, w_mag2}, w_mag1);
              r_mcand <= w_mag1;
              r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
              r_state <= ST_BUSY;
`endif
            end else begin
              r_result    <= w_fast_result;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (op_is_div(r_op)) begin
            if (w_div_done) begin
              r_result    <= w_div_result;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_result    <= mul_pick(r_op, w_prod_final);
            r_cnt       <= {CNT_W{1'b0}};
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_prod <= mul_step(r_prod, r_mcand);
            r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cmp       = r_cmp;

endmodule
